mux_bus_arbiter: RTL and testbench
==================================

Name: mux_bus_arbiter

Overview:
- Two-requester round-robin arbiter that shares one W-bit 2:1 select datapath (the gate-level 2:1 mux, replicated per bit) between requester 0 and requester 1.
- Issues registered grants, drives the mux select, and forwards the granted requester's data onto a shared bus.
- Enforces a one-cycle turnaround between owners and a maximum-hold preemption so that neither requester starves.
- Sits between the two processor-side bus masters and the shared bus consumer.

Parameters:
- DATA_W, 8: width of data0, data1 and bus_out.
- MAX_HOLD, 16: cycles a grant may be held while the other side is requesting. Legal values are 2 or more.
- HOLD_CW, 5: hold counter width. Must satisfy 2^HOLD_CW > MAX_HOLD.

Ports:
- Clock  in  1  single system clock; all state updates on its rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 wants the bus; level, held until done.
- req1  in  1  requester 1 wants the bus; level, held until done.
- done0  in  1  requester 0 releases the bus; 1-cycle pulse, honoured only while gnt0=1.
- done1  in  1  requester 1 releases the bus; 1-cycle pulse, honoured only while gnt1=1.
- data0  in  DATA_W  requester 0 data.
- data1  in  DATA_W  requester 1 data.
- gnt0  out  1  registered grant to requester 0.
- gnt1  out  1  registered grant to requester 1.
- sel  out  1  registered mux select; 0 = data0, 1 = data1.
- bus_out  out  DATA_W  combinational mux output: sel ? data1 : data0.
- bus_valid  out  1  gnt0 | gnt1.
- busy  out  1  1 whenever the state is not IDLE.

Behaviour:
- Clock and reset: one clock (Clock); reset is asynchronous and active-low (Resetn).
- Reset values: state=IDLE, gnt0=gnt1=0, sel=0, last=1 (requester 0 wins the first tie), hold_cnt=0, busy=0, bus_valid=0.
- Reset mid-grant: grants drop immediately, without waiting for a clock edge.
- States: IDLE, GRANT0, GRANT1, TURN.
- Arbitration in IDLE and TURN, evaluated on each edge:
  - req0 & req1: grant the requester != last.
  - Only one request: grant it.
  - No request: go to / remain in IDLE.
- Grant latency: a request sampled high at edge N gives gnt=1 and the new sel after edge N; bus_out is valid in the same cycle.
- On entering GRANTx: gntx=1, sel=x, last=x, hold_cnt=0.
- In GRANTx:
  - hold_cnt increments each cycle and saturates at MAX_HOLD-1.
  - Release to TURN at the edge where any of these is true: donex=1; reqx=0 (dropped request is treated as done); hold_cnt==MAX_HOLD-1 and the other req=1 (preemption).
  - If the other side is not requesting, the grant is held indefinitely.
- Release cycle: gntx=0 after the releasing edge, so there is no cycle with both grants high and no cycle with a grant during TURN.
- TURN lasts exactly one cycle, then arbitrates as IDLE does. Back-to-back ownership change therefore has exactly one bubble cycle.
- sel holds its last value in IDLE and TURN; bus_out keeps tracking that data, but bus_valid=0.
- Simultaneous done and preemption in the same cycle: a single release.
- done of a non-granted requester: ignored.
- gnt0 & gnt1 is never 1.
- A preempted requester keeps req high and re-competes; round-robin ordering guarantees it the next grant after the other owner's turn.

Decomposition:
- Shared package mux_arb_pkg: state encoding constants (IDLE=2'b00, GRANT0=2'b01, GRANT1=2'b10, TURN=2'b11) and the default DATA_W/MAX_HOLD constants.
- Sub-module arb_data_mux: a DATA_W-wide 2:1 mux built by generating one gate-level 2:1 mux per bit.
- Arbiter FSM, hold counter and last-grant register stay in mux_bus_arbiter.

Test Plan:
- Reset then idle: Resetn=0 for 2 cycles, then 1 with no requests -> gnt0=gnt1=0, sel=0, busy=0, bus_valid=0 for 5 cycles.
- Single request: req1=1, data1=8'hA5 at edge N -> gnt1=1, sel=1, bus_out=8'hA5 after N. done1 pulse at edge M -> gnt1=0 after M; busy=1 (TURN) for one cycle, then 0.
- Tie from reset: req0=req1=1 together -> gnt0 first. done0 -> one bubble cycle, then gnt1. done1 -> one bubble, then gnt0 (strict alternation over 6 grants).
- Preemption (MAX_HOLD=4): req0 granted, req1 raised at the first grant cycle, no done0 -> gnt0 drops after the 4th grant cycle, 1 bubble, then gnt1=1; req0 still high gets the grant after done1.
- No preemption without contention: req0 alone held 40 cycles with MAX_HOLD=4 -> gnt0 stays 1 throughout; hold_cnt saturates at 3.
- Async reset mid-grant: Resetn low between edges while gnt1=1 -> gnt1=0 and sel=0 immediately. After release, with req0=req1=1 -> gnt0 granted first.
- Continuous assertion over all tests: gnt0&gnt1 never 1; spurious done0 while gnt1=1 has no effect.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared state encoding and default sizing for the two-requester bus arbiter
package mux_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10,
        TURN   = 2'b11
    } state_t;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_MAX_HOLD = 16;
    localparam int DEF_HOLD_CW  = 5;
endpackage

// File: rtl/arb_data_mux.sv
// arb_data_mux: W-bit 2:1 select built from one gate-level mux per bit
module arb_data_mux #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    output logic [W-1:0] y
);
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign y[i] = (a[i] & ~s) | (b[i] & s);
    end
endmodule

// File: rtl/mux_bus_arbiter.sv
// mux_bus_arbiter: round-robin owner of a shared 2:1 data bus with one-cycle turnaround
// and max-hold preemption so neither requester starves.
module mux_bus_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int HOLD_CW  = DEF_HOLD_CW
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              req0,
    input  logic              req1,
    input  logic              done0,
    input  logic              done1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_valid,
    output logic              busy
);
    localparam logic [HOLD_CW-1:0] HOLD_MAX = HOLD_CW'(MAX_HOLD - 1);

    state_t             state, nxt;
    logic               last, pick, rel, in_grant, stay;
    logic [HOLD_CW-1:0] hold_cnt;

    // pick: 1 selects requester 1; ties go to whoever did not own the bus last
    always_comb begin
        in_grant = (state == GRANT0) || (state == GRANT1);
        pick     = (req0 & req1) ? ~last : req1;
        rel      = (state == GRANT0) ? (done0 | ~req0 | ((hold_cnt == HOLD_MAX) & req1)) :
                   (state == GRANT1) ? (done1 | ~req1 | ((hold_cnt == HOLD_MAX) & req0)) : 1'b0;
        nxt      = in_grant ? (rel ? TURN : state) :
                   !(req0 | req1) ? IDLE :
                   pick ? GRANT1 : GRANT0;
        stay     = in_grant && (nxt == state);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= IDLE;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            sel      <= 1'b0;
            last     <= 1'b1;
            hold_cnt <= '0;
        end else begin
            state    <= nxt;
            gnt0     <= (nxt == GRANT0);
            gnt1     <= (nxt == GRANT1);
            if (!in_grant && (nxt == GRANT0 || nxt == GRANT1)) begin
                sel  <= (nxt == GRANT1);
                last <= (nxt == GRANT1);
            end
            hold_cnt <= !stay ? '0 : (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_CW'(1);
        end
    end

    assign bus_valid = gnt0 | gnt1;
    assign busy      = (state != IDLE);

    arb_data_mux #(.W(DATA_W)) u_mux (
        .a(data0),
        .b(data1),
        .s(sel),
        .y(bus_out)
    );
endmodule

// File: tb/tb_mux_bus_arbiter.sv
// tb_mux_bus_arbiter: directed self-checking bench for mux_bus_arbiter (MAX_HOLD=4)
module tb_mux_bus_arbiter;
    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, done0 = 1'b0, done1 = 1'b0;
    logic [7:0] data0 = 8'h3C, data1 = 8'hA5;
    logic       gnt0, gnt1, sel, bus_valid, busy;
    logic [7:0] bus_out;
    int         n_cmp = 0;
    int         n_bad = 0;

    mux_bus_arbiter #(.DATA_W(8), .MAX_HOLD(4), .HOLD_CW(3)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .req0(req0), .req1(req1), .done0(done0), .done1(done1),
        .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
        .bus_out(bus_out), .bus_valid(bus_valid), .busy(busy)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".gnt0"}, gnt0, 0);
        chk({tag, ".gnt1"}, gnt1, 0);
        chk({tag, ".bus_valid"}, bus_valid, 0);
    endtask

    // invariants checked every cycle, away from the active edge
    always @(negedge Clock) begin
        n_cmp++;
        assert (!(gnt0 & gnt1)) else begin
            n_bad++;
            $error("FAIL both_grants observed=%0b%0b expected=not 11", gnt0, gnt1);
        end
        n_cmp++;
        assert (bus_out === (sel ? data1 : data0)) else begin
            n_bad++;
            $error("FAIL bus_mux observed=%0h expected=%0h", bus_out, sel ? data1 : data0);
        end
    end

    initial begin
        tick();
        tick();
        chk_idle("rst");
        chk("rst.sel", sel, 0);
        chk("rst.busy", busy, 0);
        Resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_idle("idle");
            chk("idle.sel", sel, 0);
            chk("idle.busy", busy, 0);
        end

        req1 = 1'b1;
        tick();
        chk("single.gnt1", gnt1, 1);
        chk("single.sel", sel, 1);
        chk("single.bus", bus_out, 8'hA5);
        chk("single.valid", bus_valid, 1);
        tick();
        done0 = 1'b1;
        tick();
        done0 = 1'b0;
        chk("spurious.gnt1", gnt1, 1);
        chk("spurious.gnt0", gnt0, 0);
        done1 = 1'b1;
        req1 = 1'b0;
        tick();
        done1 = 1'b0;
        chk_idle("single.turn");
        chk("single.turn.busy", busy, 1);
        chk("single.turn.sel", sel, 1);
        chk("single.turn.bus", bus_out, 8'hA5);
        tick();
        chk("single.idle.busy", busy, 0);
        chk("single.idle.sel", sel, 1);

        req0 = 1'b1;
        req1 = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk("rr.gnt0", gnt0, (k % 2 == 0) ? 1 : 0);
            chk("rr.gnt1", gnt1, (k % 2 == 1) ? 1 : 0);
            chk("rr.bus", bus_out, (k % 2 == 0) ? 8'h3C : 8'hA5);
            if (k % 2 == 0) done0 = 1'b1; else done1 = 1'b1;
            tick();
            done0 = 1'b0;
            done1 = 1'b0;
            chk_idle("rr.bubble");
            chk("rr.bubble.busy", busy, 1);
            tick();
        end
        chk("rr.wrap.gnt0", gnt0, 1);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        chk("rr.end.busy", busy, 0);

        req0 = 1'b1;
        tick();
        chk("pre.gnt0.c1", gnt0, 1);
        req1 = 1'b1;
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk("pre.gnt0.hold", gnt0, 1);
        end
        tick();
        chk_idle("pre.bubble");
        chk("pre.bubble.busy", busy, 1);
        tick();
        chk("pre.gnt1", gnt1, 1);
        chk("pre.sel", sel, 1);
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        chk_idle("pre.bubble2");
        tick();
        chk("pre.regrant0", gnt0, 1);
        chk("pre.regrant0.sel", sel, 0);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        chk("pre.end.busy", busy, 0);

        req0 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            chk("nopre.gnt0", gnt0, 1);
        end
        chk("nopre.hold_sat", dut.hold_cnt, 3);

        req0 = 1'b0;
        req1 = 1'b1;
        tick();
        tick();
        chk("arst.pre.gnt1", gnt1, 1);
        #2;
        Resetn = 1'b0;
        #1;
        chk("arst.gnt1", gnt1, 0);
        chk("arst.sel", sel, 0);
        chk("arst.busy", busy, 0);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        tick();
        chk("arst.tie.gnt0", gnt0, 1);
        chk("arst.tie.gnt1", gnt1, 0);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
